// File: rtl/jk_ff_pkg.sv
// rtl/jk_ff_pkg.sv - JK operation encoding and next-state helper for jk_ff_bank
package jk_ff_pkg;

    // Encoding matches the concatenation {j, k}.
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

    function automatic logic jk_next(jk_op_e op, logic q);
        logic nxt;
        case (op)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - one JK state bit with change flag and optional saturating toggle counter
// Optional feature macro: JK_FF_BANK_TOGGLE_CNT_EN (counter built when defined, else tied to 0)
// Ports: clk, reset (sync, active-high), valid, load, load_data, j, k, clear_cnt in;
//        q, changed, cnt[CNT_W-1:0] out
module jk_ff_cell
    import jk_ff_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0,
    parameter int   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             load,
    input  logic             load_data,
    input  logic             j,
    input  logic             k,
    input  logic             clear_cnt,
    output logic             q,
    output logic             changed,
    output logic [CNT_W-1:0] cnt
);

    logic q_next;

    // j/k are only looked at when valid is high, so X on them while idle
    // cannot reach q.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_data;
        end else if (valid) begin
            q_next = jk_next(jk_op_e'({j, k}), q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_BIT;
            changed <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= q_next ^ q;
        end
    end

`ifdef JK_FF_BANK_TOGGLE_CNT_EN
    logic toggle_hit;

    // Only a genuine JK toggle counts; set/clear/load edges do not, even if q flips.
    assign toggle_hit = valid & ~load & j & k;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear_cnt) begin
            cnt <= '0;
        end else if (toggle_hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_clear_cnt;

    assign unused_clear_cnt = clear_cnt;
    assign cnt              = '0;
`endif

endmodule

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - bank of WIDTH independent JK flip-flops with load, valid strobe and change mask
// Optional feature macro: JK_FF_BANK_TOGGLE_CNT_EN (per-bit saturating toggle counters)
// Ports: clk, reset (sync, active-high), valid, j, k, load, load_data, clear_cnt in;
//        q, qb, q_valid, changed, toggle_cnt (bit i at [i*CNT_W +: CNT_W]) out
module jk_ff_bank
    import jk_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [WIDTH-1:0]       j,
    input  logic [WIDTH-1:0]       k,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   clear_cnt,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qb,
    output logic                   q_valid,
    output logic [WIDTH-1:0]       changed,
    output logic [WIDTH*CNT_W-1:0] toggle_cnt
);

    // qb is a pure inversion of the register so it can never disagree with q.
    assign qb = ~q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
        end else begin
            q_valid <= valid | load;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell #(
            .RESET_BIT (RESET_VAL[i]),
            .CNT_W     (CNT_W)
        ) u_cell (
            .clk       (clk),
            .reset     (reset),
            .valid     (valid),
            .load      (load),
            .load_data (load_data[i]),
            .j         (j[i]),
            .k         (k[i]),
            .clear_cnt (clear_cnt),
            .q         (q[i]),
            .changed   (changed[i]),
            .cnt       (toggle_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - directed self-checking bench for jk_ff_bank (WIDTH=8, RESET_VAL=8'hA5, CNT_W=2)
module tb_jk_ff_bank;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   valid;
    logic [WIDTH-1:0]       j;
    logic [WIDTH-1:0]       k;
    logic                   load;
    logic [WIDTH-1:0]       load_data;
    logic                   clear_cnt;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       qb;
    logic                   q_valid;
    logic [WIDTH-1:0]       changed;
    logic [WIDTH*CNT_W-1:0] toggle_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jk_ff_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'hA5),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .j          (j),
        .k          (k),
        .load       (load),
        .load_data  (load_data),
        .clear_cnt  (clear_cnt),
        .q          (q),
        .qb         (qb),
        .q_valid    (q_valid),
        .changed    (changed),
        .toggle_cnt (toggle_cnt)
    );

    // Counter expectation depends on whether the optional counters are built.
    function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef JK_FF_BANK_TOGGLE_CNT_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset     = 1'b0;
        valid     = 1'b0;
        j         = '0;
        k         = '0;
        load      = 1'b0;
        load_data = '0;
        clear_cnt = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset     = 1'b1;
        load      = 1'b1;
        load_data = 8'h0F;
        valid     = 1'b1;
        j         = 8'hFF;
        k         = 8'hFF;
        step();
        step();
        set_idle();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 8'hA5); end
        checks++; if (qb !== 8'h5A) begin errors++; $display("FAIL reset_qb got=%h exp=%h", qb, 8'h5A); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
        checks++; if (changed !== 8'h00) begin errors++; $display("FAIL reset_changed got=%h exp=00", changed); end
        checks++; if (toggle_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", toggle_cnt); end
    endtask

    task automatic test_load_zero();
        load      = 1'b1;
        load_data = 8'h00;
        step();
        set_idle();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL load0_q got=%h exp=00", q); end
        checks++; if (changed !== 8'hA5) begin errors++; $display("FAIL load0_changed got=%h exp=a5", changed); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL load0_q_valid got=%b exp=1", q_valid); end
        step();
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL idle_q_valid got=%b exp=0", q_valid); end
        checks++; if (changed !== 8'h00) begin errors++; $display("FAIL idle_changed got=%h exp=00", changed); end
    endtask

    // bits7:6 {j,k}=11 toggle, 5:4 =10 set, 3:2 =01 clear, 1:0 =00 hold
    task automatic test_all_ops();
        valid = 1'b1;
        j     = 8'hF0;
        k     = 8'hCC;
        step();
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL ops1_q got=%h exp=f0", q); end
        checks++; if (changed !== 8'hF0) begin errors++; $display("FAIL ops1_changed got=%h exp=f0", changed); end
        checks++; if (qb !== 8'h0F) begin errors++; $display("FAIL ops1_qb got=%h exp=0f", qb); end
        step();
        set_idle();
        checks++; if (q !== 8'h30) begin errors++; $display("FAIL ops2_q got=%h exp=30", q); end
        checks++; if (changed !== 8'hC0) begin errors++; $display("FAIL ops2_changed got=%h exp=c0", changed); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL ops2_q_valid got=%b exp=1", q_valid); end
        checks++; if (toggle_cnt !== exp_cnt(16'hA000)) begin errors++; $display("FAIL ops2_cnt got=%h exp=%h", toggle_cnt, exp_cnt(16'hA000)); end
    endtask

    task automatic test_qualifier();
        valid = 1'b0;
        j     = 8'hFF;
        k     = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++; if (q !== 8'h30) begin errors++; $display("FAIL qual_q cyc=%0d got=%h exp=30", n, q); end
            checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL qual_q_valid cyc=%0d got=%b exp=0", n, q_valid); end
        end
        j = 'x;
        k = 'x;
        step();
        checks++; if (q !== 8'h30) begin errors++; $display("FAIL qual_x_q got=%h exp=30", q); end
        set_idle();
        checks++; if (toggle_cnt !== exp_cnt(16'hA000)) begin errors++; $display("FAIL qual_cnt got=%h exp=%h", toggle_cnt, exp_cnt(16'hA000)); end
    endtask

    task automatic test_load_priority();
        load      = 1'b1;
        load_data = 8'h3C;
        valid     = 1'b1;
        j         = 8'hFF;
        k         = 8'hFF;
        step();
        set_idle();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL ldpri_q got=%h exp=3c", q); end
        checks++; if (changed !== 8'h0C) begin errors++; $display("FAIL ldpri_changed got=%h exp=0c", changed); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL ldpri_q_valid got=%b exp=1", q_valid); end
        checks++; if (toggle_cnt !== exp_cnt(16'hA000)) begin errors++; $display("FAIL ldpri_cnt got=%h exp=%h", toggle_cnt, exp_cnt(16'hA000)); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_c;
        valid = 1'b1;
        j     = 8'h01;
        k     = 8'h01;
        for (int n = 1; n <= 5; n++) begin
            step();
            exp_c = 16'hA000 | 16'((n > 3) ? 3 : n);
            checks++; if (q[0] !== n[0]) begin errors++; $display("FAIL sat_q0 n=%0d got=%b exp=%b", n, q[0], n[0]); end
            checks++; if (toggle_cnt !== exp_cnt(exp_c)) begin errors++; $display("FAIL sat_cnt n=%0d got=%h exp=%h", n, toggle_cnt, exp_cnt(exp_c)); end
        end
        clear_cnt = 1'b1;
        step();
        set_idle();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL clr_q got=%h exp=3c", q); end
        checks++; if (toggle_cnt !== 16'h0000) begin errors++; $display("FAIL clr_cnt got=%h exp=0000", toggle_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_q [4];
        logic [15:0] exp_c [4];
        exp_q = '{8'hC3, 8'h3C, 8'hC3, 8'h3C};
        exp_c = '{16'h5555, 16'hAAAA, 16'hFFFF, 16'hFFFF};
        valid = 1'b1;
        j     = 8'hFF;
        k     = 8'hFF;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++; if (q !== exp_q[n]) begin errors++; $display("FAIL b2b_q n=%0d got=%h exp=%h", n, q, exp_q[n]); end
            checks++; if (changed !== 8'hFF) begin errors++; $display("FAIL b2b_changed n=%0d got=%h exp=ff", n, changed); end
            checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL b2b_q_valid n=%0d got=%b exp=1", n, q_valid); end
            checks++; if (toggle_cnt !== exp_cnt(exp_c[n])) begin errors++; $display("FAIL b2b_cnt n=%0d got=%h exp=%h", n, toggle_cnt, exp_cnt(exp_c[n])); end
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        reset     = 1'b1;
        load      = 1'b1;
        load_data = 8'h55;
        step();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL rstmid_q got=%h exp=a5", q); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rstmid_q_valid got=%b exp=0", q_valid); end
        checks++; if (changed !== 8'h00) begin errors++; $display("FAIL rstmid_changed got=%h exp=00", changed); end
        checks++; if (toggle_cnt !== 16'h0000) begin errors++; $display("FAIL rstmid_cnt got=%h exp=0000", toggle_cnt); end
        reset = 1'b0;
        step();
        set_idle();
        checks++; if (q !== 8'h55) begin errors++; $display("FAIL postrst_q got=%h exp=55", q); end
        checks++; if (changed !== 8'hF0) begin errors++; $display("FAIL postrst_changed got=%h exp=f0", changed); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL postrst_q_valid got=%b exp=1", q_valid); end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_zero();
        test_all_ops();
        test_qualifier();
        test_load_priority();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
